// File: rtl/sipo_frame_rx.sv
// Serial-in, parallel-out frame receiver: start bit, WIDTH data bits LSB first,
// optional parity bit, stop bit; delivers a checked word with a one-cycle pulse.
module sipo_frame_rx #(
    parameter int WIDTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic          ODD  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_q, par_d;
    logic             bad_q, bad_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             busy_q, busy_d;

    // valid is a one-cycle strobe with no ready: the downstream register must
    // load data_out in the cycle valid is high; data_out holds otherwise.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        par_d        = par_q;
        bad_d        = bad_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        bad_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {sin, shift_q[WIDTH-1:1]};
                    par_d   = par_q ^ sin;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    bad_d   = ((par_q ^ sin) != ODD);
                    state_d = STOP;
                end
                STOP: begin
                    // A low stop bit never starts a new frame; back to IDLE first.
                    state_d      = IDLE;
                    frame_err_d  = !sin;
                    parity_err_d = bad_q;
                    if (sin && !bad_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            bad_q        <= 1'b0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            par_q        <= par_d;
            bad_q        <= bad_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed and randomized frames against a frame-level reference model:
// each frame's expected word/flags are computed arithmetically from its bits.
module tb_sipo_frame_rx;

    localparam int   W    = 4;
    localparam int   PEN  = 1;
    localparam logic PODD = 1'b0;

    logic         clk;
    logic         reset;
    logic         sin;
    logic         bit_en;
    logic [W-1:0] data_out;
    logic         valid;
    logic         frame_err;
    logic         parity_err;
    logic         busy;
    logic [1:0]   state_dbg;

    int           n_assert;
    int           n_fail;
    logic [W-1:0] exp_data;

    sipo_frame_rx #(
        .WIDTH     (W),
        .PARITY_EN (PEN),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .bit_en    (bit_en),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, check all outputs 1ns after the rising edge.
    task automatic tick(input logic en, input logic s, input logic e_busy, input logic e_valid,
                        input logic e_ferr, input logic e_perr, input string tag);
        @(negedge clk);
        bit_en = en;
        sin    = s;
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk({tag, "_valid"}, 32'(valid), 32'(e_valid));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(e_ferr));
        chk({tag, "_parity_err"}, 32'(parity_err), 32'(e_perr));
        chk({tag, "_data_out"}, 32'(data_out), 32'(exp_data));
    endtask

    task automatic gaps(input int n, input logic e_busy, input string tag);
        logic r;
        for (int g = 0; g < n; g++) begin
            r = 1'($urandom_range(0, 1));
            tick(1'b0, r, e_busy, 1'b0, 1'b0, 1'b0, {tag, "_gap"});
        end
    endtask

    // Reference model: a frame is good iff stop=1 and data^parity matches the mode.
    task automatic send_frame(input logic [W-1:0] d, input logic pb, input logic sb,
                              input int gap, input string tag);
        logic ok_par;
        logic good;
        ok_par = (PEN == 0) || (((^d) ^ pb) == PODD);
        good   = sb && ok_par;
        gaps(gap, 1'b0, tag);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_start"});
        for (int i = 0; i < W; i++) begin
            gaps(gap, 1'b1, tag);
            tick(1'b1, d[i], 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_data"});
        end
        if (PEN != 0) begin
            gaps(gap, 1'b1, tag);
            tick(1'b1, pb, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_parity"});
        end
        gaps(gap, 1'b1, tag);
        if (good) exp_data = d;
        tick(1'b1, sb, 1'b0, good, !sb, !ok_par, {tag, "_stop"});
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rp;
        logic         rs;
        int           rg;
        n_assert = 0;
        n_fail   = 0;
        exp_data = '0;
        reset    = 1'b0;
        sin      = 1'b1;
        bit_en   = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // good frame 4'hB, then abort a frame with reset mid-DATA
        send_frame(4'hB, 1'b1, 1'b1, 0, "good_b");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_b");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "abort_start");
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "abort_d0");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "abort_d1");
        @(negedge clk);
        sin = 1'b1;
        #2 reset = 1'b0;
        #1;
        exp_data = '0;
        chk("mid_rst_data_out", 32'(data_out), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_ferr", 32'(frame_err), 32'h0);
        chk("mid_rst_perr", 32'(parity_err), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_state", 32'(state_dbg), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_idle");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_idle2");

        // directed frames from the test plan
        send_frame(4'hB, 1'b1, 1'b1, 0, "good_b2");
        send_frame(4'hB, 1'b0, 1'b1, 1, "par_err");
        send_frame(4'h8, 1'b1, 1'b0, 0, "frm_err");
        send_frame(4'h3, 1'b1, 1'b0, 0, "both_err");
        send_frame(4'h0, 1'b0, 1'b1, 0, "good_0");
        send_frame(4'hB, 1'b1, 1'b1, 2, "gated_b");
        send_frame(4'hB, 1'b1, 1'b1, 0, "b2b_b");
        send_frame(4'h5, 1'b0, 1'b1, 0, "b2b_5");
        send_frame(4'hF, 1'b0, 1'b1, 0, "good_f");

        // randomized frames, random parity/stop errors and strobe spacing
        for (int k = 0; k < 40; k++) begin
            rd = W'($urandom_range(0, (1 << W) - 1));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            rg = $urandom_range(0, 2);
            send_frame(rd, rp, rs, rg, "rand");
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "final_idle");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "final_idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
